list_closest_hit: RTL and testbench

Per-ray closest-hit accumulator sitting directly downstream of the intersection unit's list output. It consumes one `int_to_list_t` result per triangle test, keeps the nearest hit found so far for each in-flight ray, and emits one final `list_to_ss_t` record per ray once the last triangle of its leaf list has been tested. Shadow (occlusion) rays resolve on their first hit. The output feeds the shading/scheduling stage.

---
 rtl/list_closest_hit.sv | 164 ++++++++++++++++
 tb/tb_list_closest_hit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/list_closest_hit.sv
// list_closest_hit: per-ray closest-hit accumulator between the intersection
// unit and the shading/scheduling stage. Keeps the nearest hit per in-flight
// ray and emits one final record per ray; occlusion rays resolve on first hit.
// Optional feature macro: LIST_STATS_EN adds stat_rays_done / stat_rays_hit.

package list_closest_hit_pkg;
  typedef logic [31:0] float_t;
  typedef struct packed { float_t u; float_t v; } bari_uv_t;
  typedef struct packed { logic [7:0] rayID; logic is_occular; } ray_info_t;
  typedef logic [15:0] tri_id_t;
  typedef struct packed {
    ray_info_t ray_info;
    tri_id_t   triID;
    logic      hit;
    logic      is_last;
    float_t    t_int;
    bari_uv_t  uv;
  } int_to_list_t;
  typedef struct packed {
    ray_info_t ray_info;
    tri_id_t   triID;
    logic      hit;
    float_t    t_int;
    bari_uv_t  uv;
  } list_to_ss_t;
endpackage

module list_closest_hit
  import list_closest_hit_pkg::*;
#(
  parameter int NUM_RAYS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         int_to_list_valid,
  input  int_to_list_t int_to_list_data,
  output logic         int_to_list_stall,
  output logic         list_to_ss_valid,
  output list_to_ss_t  list_to_ss_data,
  input  logic         list_to_ss_stall
`ifdef LIST_STATS_EN
  ,
  output logic [31:0]  stat_rays_done,
  output logic [31:0]  stat_rays_hit
`endif
);

  localparam int IDX_W = $clog2(NUM_RAYS);

  // Ray table: valid bits are reset, payload storage is not.
  logic [NUM_RAYS-1:0] valid_r;
  tri_id_t             tri_r [NUM_RAYS];
  float_t              t_r   [NUM_RAYS];
  bari_uv_t            uv_r  [NUM_RAYS];

  logic                out_valid_r;
  list_to_ss_t         out_data_r;

  logic [IDX_W-1:0]    idx_s;
  logic                accept_s;
  logic                final_s;
  logic                closer_s;
  logic                entry_valid_s;
  float_t              entry_t_s;
  logic                wr_en_s;
  logic                clr_en_s;
  logic                out_fire_s;
  list_to_ss_t         rec_s;

  assign idx_s             = int_to_list_data.ray_info.rayID[IDX_W-1:0];
  assign int_to_list_stall = out_valid_r & list_to_ss_stall;
  assign accept_s          = int_to_list_valid & ~int_to_list_stall;
  assign out_fire_s        = out_valid_r & ~list_to_ss_stall;
  assign list_to_ss_valid  = out_valid_r;
  assign list_to_ss_data   = out_data_r;

  // Table lookup and closest-hit decision for the incoming result.
  always_comb begin
    entry_valid_s = valid_r[idx_s];
    entry_t_s     = t_r[idx_s];
    final_s       = int_to_list_data.is_last |
                    (int_to_list_data.hit & int_to_list_data.ray_info.is_occular);
    // Hits always carry positive t, so the magnitude bits order as unsigned;
    // strict less-than keeps the earlier triangle on a tie.
    closer_s      = int_to_list_data.hit &
                    (~entry_valid_s | (int_to_list_data.t_int[30:0] < entry_t_s[30:0]));
    wr_en_s       = accept_s & ~final_s & closer_s;
    clr_en_s      = accept_s & final_s;
  end

  // Build the final record from either the new hit, the stored hit, or a miss.
  always_comb begin
    rec_s          = '0;
    rec_s.ray_info = int_to_list_data.ray_info;
    if (closer_s) begin
      rec_s.triID = int_to_list_data.triID;
      rec_s.hit   = 1'b1;
      rec_s.t_int = int_to_list_data.t_int;
      rec_s.uv    = int_to_list_data.uv;
    end else if (entry_valid_s) begin
      rec_s.triID = tri_r[idx_s];
      rec_s.hit   = 1'b1;
      rec_s.t_int = t_r[idx_s];
      rec_s.uv    = uv_r[idx_s];
    end else begin
      rec_s.hit   = 1'b0;
    end
  end

  // Entry valid bits: set on a closer non-final hit, cleared on finalize.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (clr_en_s) begin
      valid_r[idx_s] <= 1'b0;
    end else if (wr_en_s) begin
      valid_r[idx_s] <= 1'b1;
    end
  end

  // Entry payload write for a closer non-final hit.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tri_r[idx_s] <= int_to_list_data.triID;
      t_r[idx_s]   <= int_to_list_data.t_int;
      uv_r[idx_s]  <= int_to_list_data.uv;
    end
  end

  // Single-slot output register; a drain and a new load may share one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (clr_en_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= rec_s;
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef LIST_STATS_EN
  logic [31:0] done_r;
  logic [31:0] hit_r;

  // Count output handshakes, and those carrying a hit; both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_r <= 32'd0;
      hit_r  <= 32'd0;
    end else if (out_fire_s) begin
      done_r <= done_r + 32'd1;
      if (out_data_r.hit) begin
        hit_r <= hit_r + 32'd1;
      end
    end
  end

  assign stat_rays_done = done_r;
  assign stat_rays_hit  = hit_r;
`endif

endmodule

// File: tb/tb_list_closest_hit.sv
module tb_list_closest_hit;
  import list_closest_hit_pkg::*;

  localparam logic [31:0] F0_5 = 32'h3F00_0000;
  localparam logic [31:0] F1_0 = 32'h3F80_0000;
  localparam logic [31:0] F1_5 = 32'h3FC0_0000;
  localparam logic [31:0] F2_0 = 32'h4000_0000;
  localparam logic [31:0] F3_0 = 32'h4040_0000;
  localparam logic [31:0] F4_0 = 32'h4080_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  int_to_list_t in_data = '0;
  logic         in_stall;
  logic         out_valid;
  list_to_ss_t  out_data;
  logic         out_stall = 1'b0;
`ifdef LIST_STATS_EN
  logic [31:0]  stat_done;
  logic [31:0]  stat_hit;
`endif

  int checks = 0;
  int failures = 0;
  list_to_ss_t exp_rec;

  always #5 clk = ~clk;

  list_closest_hit #(.NUM_RAYS(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .int_to_list_valid (in_valid),
    .int_to_list_data  (in_data),
    .int_to_list_stall (in_stall),
    .list_to_ss_valid  (out_valid),
    .list_to_ss_data   (out_data),
    .list_to_ss_stall  (out_stall)
`ifdef LIST_STATS_EN
    ,
    .stat_rays_done    (stat_done),
    .stat_rays_hit     (stat_hit)
`endif
  );

  // Expected output record; a miss carries all-zero payload.
  function automatic list_to_ss_t mk(input logic [7:0] rid, input logic occ,
                                     input logic [15:0] tri_id, input logic hit,
                                     input logic [31:0] t, input logic [31:0] uvv);
    list_to_ss_t r;
    r = '0;
    r.ray_info.rayID = rid;
    r.ray_info.is_occular = occ;
    r.hit = hit;
    if (hit) begin
      r.triID = tri_id;
      r.t_int = t;
      r.uv.u  = uvv;
      r.uv.v  = ~uvv;
    end
    return r;
  endfunction

  // Present one result for exactly one clock edge.
  task automatic push(input logic [7:0] rid, input logic occ, input logic [15:0] tri_id,
                      input logic hit, input logic last, input logic [31:0] t,
                      input logic [31:0] uvv);
    in_data.ray_info.rayID = rid;
    in_data.ray_info.is_occular = occ;
    in_data.triID = tri_id;
    in_data.hit = hit;
    in_data.is_last = last;
    in_data.t_int = t;
    in_data.uv.u = uvv;
    in_data.uv.v = ~uvv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_stall = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (in_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", in_stall); end
`ifdef LIST_STATS_EN
    checks++; if (stat_done !== 32'd0 || stat_hit !== 32'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_done, stat_hit); end
`endif
    out_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle();
  endtask

  task automatic test_stats_and_midreset();
    push(8'd1, 1'b0, 16'd1, 1'b1, 1'b1, F1_0, 32'h11);
    push(8'd2, 1'b0, 16'd2, 1'b0, 1'b1, F1_0, 32'h22);
    push(8'd3, 1'b0, 16'd3, 1'b1, 1'b1, F2_0, 32'h33);
    idle();
`ifdef LIST_STATS_EN
    checks++; if (stat_done !== 32'd3) begin failures++; $display("FAIL stat_done got=%0d exp=3", stat_done); end
    checks++; if (stat_hit !== 32'd2) begin failures++; $display("FAIL stat_hit got=%0d exp=2", stat_hit); end
`endif
    push(8'd8, 1'b0, 16'd80, 1'b1, 1'b0, F1_0, 32'h88);
    push(8'd4, 1'b0, 16'd4, 1'b1, 1'b1, F1_0, 32'h44);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midreset_pending got=%b exp=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL midreset_data got=%h exp=0", out_data); end
`ifdef LIST_STATS_EN
    checks++; if (stat_done !== 32'd0 || stat_hit !== 32'd0) begin failures++; $display("FAIL midreset_stats got=%0d/%0d exp=0/0", stat_done, stat_hit); end
`endif
    @(negedge clk);
    rst = 1'b1;
    idle();
    push(8'd8, 1'b0, 16'd81, 1'b0, 1'b1, F1_0, 32'h89);
    exp_rec = mk(8'd8, 1'b0, 16'd0, 1'b0, 32'd0, 32'd0);
    checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL midreset_discard got=%h exp=%h", out_data, exp_rec); end
    idle();
  endtask

  task automatic test_closest();
    push(8'd5, 1'b0, 16'd1, 1'b1, 1'b0, F3_0, 32'hA1);
    push(8'd5, 1'b0, 16'd2, 1'b1, 1'b0, F1_5, 32'hA2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL closest_nofinal got=%b exp=0", out_valid); end
    push(8'd5, 1'b0, 16'd3, 1'b1, 1'b1, F2_0, 32'hA3);
    exp_rec = mk(8'd5, 1'b0, 16'd2, 1'b1, F1_5, 32'hA2);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL closest_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL closest_data got=%h exp=%h", out_data, exp_rec); end
    idle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL closest_drain got=%b exp=0", out_valid); end
    push(8'd5, 1'b0, 16'd4, 1'b0, 1'b1, F1_0, 32'hA4);
    exp_rec = mk(8'd5, 1'b0, 16'd0, 1'b0, 32'd0, 32'd0);
    checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL closest_cleared got=%h exp=%h", out_data, exp_rec); end
    idle();
  endtask

  task automatic test_miss();
    push(8'd7, 1'b0, 16'd70, 1'b0, 1'b0, F1_0, 32'hB1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL miss_nooutput got=%b exp=0", out_valid); end
    push(8'd7, 1'b0, 16'd71, 1'b0, 1'b1, F2_0, 32'hB2);
    exp_rec = mk(8'd7, 1'b0, 16'd0, 1'b0, 32'd0, 32'd0);
    checks++; if (out_valid !== 1'b1 || out_data !== exp_rec) begin failures++; $display("FAIL miss_data got=%b/%h exp=1/%h", out_valid, out_data, exp_rec); end
    push(8'd7, 1'b0, 16'd72, 1'b0, 1'b1, F2_0, 32'hB3);
    checks++; if (out_data.hit !== 1'b0) begin failures++; $display("FAIL miss_entry7_invalid got=%b exp=0", out_data.hit); end
    idle();
  endtask

  task automatic test_occlusion();
    push(8'd9, 1'b1, 16'd90, 1'b1, 1'b0, F0_5, 32'hC1);
    exp_rec = mk(8'd9, 1'b1, 16'd90, 1'b1, F0_5, 32'hC1);
    checks++; if (out_valid !== 1'b1 || out_data !== exp_rec) begin failures++; $display("FAIL occl_data got=%b/%h exp=1/%h", out_valid, out_data, exp_rec); end
    push(8'd9, 1'b0, 16'd20, 1'b1, 1'b0, F4_0, 32'hC2);
    push(8'd9, 1'b0, 16'd21, 1'b0, 1'b1, F1_0, 32'hC3);
    exp_rec = mk(8'd9, 1'b0, 16'd20, 1'b1, F4_0, 32'hC2);
    checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL occl_fresh got=%h exp=%h", out_data, exp_rec); end
    idle();
  endtask

  task automatic test_tie();
    push(8'd11, 1'b0, 16'd10, 1'b1, 1'b0, F2_0, 32'hD1);
    push(8'd11, 1'b0, 16'd11, 1'b1, 1'b1, F2_0, 32'hD2);
    exp_rec = mk(8'd11, 1'b0, 16'd10, 1'b1, F2_0, 32'hD1);
    checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL tie_data got=%h exp=%h", out_data, exp_rec); end
    idle();
  endtask

  task automatic test_index_trunc();
    push(8'd70, 1'b0, 16'd30, 1'b1, 1'b0, F1_0, 32'hE1);
    push(8'd6, 1'b0, 16'd31, 1'b0, 1'b1, F2_0, 32'hE2);
    exp_rec = mk(8'd6, 1'b0, 16'd30, 1'b1, F1_0, 32'hE1);
    checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL trunc_data got=%h exp=%h", out_data, exp_rec); end
    idle();
  endtask

  task automatic test_back_to_back_stall();
    list_to_ss_t exp13;
    out_stall = 1'b1;
    push(8'd12, 1'b0, 16'd40, 1'b1, 1'b1, F1_0, 32'hF1);
    exp_rec = mk(8'd12, 1'b0, 16'd40, 1'b1, F1_0, 32'hF1);
    exp13   = mk(8'd13, 1'b0, 16'd0, 1'b0, 32'd0, 32'd0);
    in_data.ray_info.rayID = 8'd13;
    in_data.ray_info.is_occular = 1'b0;
    in_data.triID = 16'd41;
    in_data.hit = 1'b0;
    in_data.is_last = 1'b1;
    in_valid = 1'b1;
    checks++; if (in_stall !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", in_stall); end
    for (int c = 0; c < 4; c++) begin
      idle();
      checks++; if (in_stall !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%b exp=1/1", c, in_stall, out_valid); end
      checks++; if (out_data !== exp_rec) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, out_data, exp_rec); end
    end
    out_stall = 1'b0;
    #1;
    checks++; if (in_stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", in_stall); end
    idle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== exp13) begin failures++; $display("FAIL drain_accept got=%b/%h exp=1/%h", out_valid, out_data, exp13); end
    idle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_final got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stats_and_midreset();
    test_closest();
    test_miss();
    test_occlusion();
    test_tie();
    test_index_trunc();
    test_back_to_back_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
